// File: rtl/uart_str_tx_if.sv
// Trigger/status/serial-line bundle for uart_str_tx.
// The master drives the trigger strobe and the slave (the transmitter) drives the status and tx line.
interface uart_str_tx_if;
   logic trigger;
   logic busy;
   logic done;
   logic tx;

   modport master (output trigger, input busy, input done, input tx);
   modport slave  (input trigger, output busy, output done, output tx);
endinterface

// File: rtl/uart_str_tx.sv
// Fixed-message UART transmitter: one trigger sends msg LSB-first as 8N1/8N2 frames.
// Define UART_STR_TX_CRLF_EN to append 0x0D 0x0A after the last msg byte.
module uart_str_tx #(
   parameter int unsigned           sys_clk_freq = 50_000_000,
   parameter int unsigned           baudrate     = 115200,
   parameter int unsigned           msg_len      = 1,
   parameter logic [8*msg_len-1:0]  msg          = 8'h61,
   parameter int unsigned           stop_bits    = 1
) (
   input  logic         sclk,
   input  logic         nrst,
   uart_str_tx_if.slave bus
);

   localparam int unsigned BitCyc = sys_clk_freq / baudrate;
   localparam int unsigned BaudW  = $clog2(BitCyc);
`ifdef UART_STR_TX_CRLF_EN
   localparam int unsigned NumBytes = msg_len + 2;
`else
   localparam int unsigned NumBytes = msg_len;
`endif

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e           state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             baud_last;

   // Byte idx of the transmitted stream; msg is sent most-significant byte first.
   function automatic logic [7:0] byte_at(input logic [7:0] idx);
      logic [8*msg_len-1:0] sh;
      sh      = msg << {idx, 3'b000};
      byte_at = sh[8*msg_len-1 -: 8];
`ifdef UART_STR_TX_CRLF_EN
      if (idx == 8'(msg_len)) begin
         byte_at = 8'h0D;
      end else if (idx == 8'(msg_len + 1)) begin
         byte_at = 8'h0A;
      end
`endif
   endfunction

   assign baud_last = (baud_q == BaudW'(BitCyc - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.trigger) begin
               state_d = StStart;
               idx_d   = '0;
               shift_d = byte_at(8'd0);
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         StStart: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;  // wraps to 0 for the stop-bit count
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'(stop_bits - 1)) begin
                  bit_d = '0;
                  if (idx_q == 8'(NumBytes - 1)) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     idx_d   = idx_q + 8'd1;
                     shift_d = byte_at(idx_q + 8'd1);
                     state_d = StStart;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so tx/busy change on the accepting edge.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != StIdle);
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.tx   = tx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
